// File: rtl/jtag_debug_sysclk_cmd_decoder_if.sv
// Command handshake bus between the sysclk decoder (master) and its consumer (slave).
interface jtag_debug_sysclk_cmd_decoder_if #(
    parameter int unsigned IR_W = 2,
    parameter int unsigned DR_W = 38
);
    localparam int unsigned NCMD = 2 ** IR_W;

    logic [DR_W-1:0] jdo;
    logic [IR_W-1:0] cmd_ir;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [NCMD-1:0] take_action;
    logic [NCMD-1:0] take_no_action;

    modport master (
        output jdo,
        output cmd_ir,
        output cmd_valid,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  jdo,
        input  cmd_ir,
        input  cmd_valid,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_sysclk_cmd_decoder.sv
// Sysclk-side JTAG debug command decoder: synchronises update-IR/DR strobes,
// captures the scanned DR into a one-entry command slot with valid/ready,
// decodes per-command strobes and tracks dropped updates.
module jtag_debug_sysclk_cmd_decoder #(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DR_W        = 38,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = DR_W - 1,
    parameter int unsigned OVR_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DR_W-1:0]      sr,
    input  logic                 clr_overrun,
    jtag_debug_sysclk_cmd_decoder_if.master cmd,
    output logic                 overrun,
    output logic [OVR_W-1:0]     overrun_count
);
    localparam int unsigned NCMD = 2 ** IR_W;
    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_d;
    logic                   udr_d;
    logic                   uir_p;
    logic                   udr_p;

    logic [IR_W-1:0]        ir_q;
    logic [DR_W-1:0]        jdo_q;
    logic [IR_W-1:0]        cmd_ir_q;
    logic                   cmd_valid_q;

    logic                   slot_free;
    logic                   load;
    logic                   drop;

    logic [NCMD-1:0]        act_c;
    logic [NCMD-1:0]        no_act_c;

    // Strobe synchronisers plus one delay flop each for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_d    <= 1'b0;
            udr_d    <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_d    <= uir_sync[SYNC_STAGES-1];
            udr_d    <= udr_sync[SYNC_STAGES-1];
        end
    end

    assign uir_p     = uir_sync[SYNC_STAGES-1] & ~uir_d;
    assign udr_p     = udr_sync[SYNC_STAGES-1] & ~udr_d;
    // Slot is free when empty or being accepted this cycle (no bubble on reload).
    assign slot_free = ~cmd_valid_q | cmd.cmd_ready;
    assign load      = udr_p & slot_free;
    assign drop      = udr_p & ~slot_free;

    // Latest IR scan, used when the DR update arrives without a fresh IR update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
        end else if (uir_p) begin
            ir_q <= ir_in;
        end
    end

    // Command slot: load on a free-slot update, retire on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q       <= '0;
            cmd_ir_q    <= '0;
            cmd_valid_q <= 1'b0;
        end else if (load) begin
            jdo_q       <= sr;
            cmd_ir_q    <= uir_p ? ir_in : ir_q;
            cmd_valid_q <= 1'b1;
        end else if (cmd_valid_q && cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

    // Overrun flag and saturating drop counter; a drop beats a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (clr_overrun) begin
                overrun_count <= OVR_W'(1);
            end else if (overrun_count != OVR_MAX) begin
                overrun_count <= overrun_count + OVR_W'(1);
            end
        end else if (clr_overrun) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end
    end

    // One-hot command decode from the registered slot.
    always_comb begin
        act_c    = '0;
        no_act_c = '0;
        if (cmd_valid_q) begin
            if (jdo_q[ACT_BIT]) begin
                act_c[cmd_ir_q] = 1'b1;
            end else begin
                no_act_c[cmd_ir_q] = 1'b1;
            end
        end
    end

    assign cmd.jdo            = jdo_q;
    assign cmd.cmd_ir         = cmd_ir_q;
    assign cmd.cmd_valid      = cmd_valid_q;
    assign cmd.take_action    = act_c;
    assign cmd.take_no_action = no_act_c;
endmodule

// File: tb/tb_jtag_debug_sysclk_cmd_decoder.sv
// Bench for the sysclk JTAG command decoder: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_jtag_debug_sysclk_cmd_decoder;
    localparam int unsigned IR_W  = 2;
    localparam int unsigned DR_W  = 38;
    localparam int unsigned S     = 2;
    localparam int unsigned OVR_W = 2;
    localparam int unsigned ACT   = DR_W - 1;
    localparam int          CMAX  = (1 << OVR_W) - 1;

    localparam logic [DR_W-1:0] VA = 38'h20_0000_1234;
    localparam logic [DR_W-1:0] VB = 38'h00_0000_5678;
    localparam logic [DR_W-1:0] VC = 38'h00_0000_00C3;
    localparam logic [DR_W-1:0] VD = 38'h3F_FFFF_FFFF;
    localparam logic [DR_W-1:0] VZ = 38'h0;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            vs_uir;
    logic            vs_udr;
    logic [IR_W-1:0] ir_in;
    logic [DR_W-1:0] sr;
    logic            clr_overrun;
    logic            overrun;
    logic [OVR_W-1:0] overrun_count;

    jtag_debug_sysclk_cmd_decoder_if #(.IR_W(IR_W), .DR_W(DR_W)) bus ();

    jtag_debug_sysclk_cmd_decoder #(
        .IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(S), .ACT_BIT(ACT), .OVR_W(OVR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vs_uir       (vs_uir),
        .vs_udr       (vs_udr),
        .ir_in        (ir_in),
        .sr           (sr),
        .clr_overrun  (clr_overrun),
        .cmd          (bus.master),
        .overrun      (overrun),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: command slot state plus raw level history per strobe.
    bit              m_valid;
    logic [IR_W-1:0] m_ir, m_irq;
    logic [DR_W-1:0] m_jdo;
    bit              m_ovr;
    int              m_cnt;
    bit              hist_u [0:S];
    bit              hist_d [0:S];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ir = '0; m_irq = '0; m_jdo = '0; m_ovr = 0; m_cnt = 0;
        for (int k = 0; k <= S; k++) begin
            hist_u[k] = 0;
            hist_d[k] = 0;
        end
    endtask

    // A strobe is seen as a fresh rise once it has been high for S samples
    // after having been low the sample before.
    task automatic model_step(bit u, bit d, logic [IR_W-1:0] ir, logic [DR_W-1:0] s,
                              bit rdy, bit clr);
        bit up, dp, free, drop;
        up   = hist_u[S-1] && !hist_u[S];
        dp   = hist_d[S-1] && !hist_d[S];
        free = !m_valid || rdy;
        drop = dp && !free;
        if (dp && free) begin
            m_jdo   = s;
            m_ir    = up ? ir : m_irq;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop) begin
            m_ovr = 1;
            m_cnt = clr ? 1 : ((m_cnt >= CMAX) ? CMAX : m_cnt + 1);
        end else if (clr) begin
            m_ovr = 0;
            m_cnt = 0;
        end
        if (up) m_irq = ir;
        for (int k = S; k > 0; k--) begin
            hist_u[k] = hist_u[k-1];
            hist_d[k] = hist_d[k-1];
        end
        hist_u[0] = u;
        hist_d[0] = d;
    endtask

    task automatic check_model(string tag);
        logic [3:0] eta, etna;
        eta = '0;
        etna = '0;
        if (m_valid) begin
            if (m_jdo[ACT]) eta[m_ir] = 1'b1;
            else            etna[m_ir] = 1'b1;
        end
        chk({tag, ".valid"}, 64'(bus.cmd_valid), 64'(m_valid));
        chk({tag, ".jdo"},   64'(bus.jdo), 64'(m_jdo));
        chk({tag, ".ir"},    64'(bus.cmd_ir), 64'(m_ir));
        chk({tag, ".ta"},    64'(bus.take_action), 64'(eta));
        chk({tag, ".tna"},   64'(bus.take_no_action), 64'(etna));
        chk({tag, ".ovr"},   64'(overrun), 64'(m_ovr));
        chk({tag, ".cnt"},   64'(overrun_count), 64'(m_cnt));
    endtask

    // One clock: capture inputs, advance model at the edge, compare 1 ns later.
    task automatic tick(string tag);
        bit u, d, rdy, clr;
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] s;
        u = vs_uir; d = vs_udr; ir = ir_in; s = sr; rdy = bus.cmd_ready; clr = clr_overrun;
        @(posedge clk);
        model_step(u, d, ir, s, rdy, clr);
        #1;
        check_model(tag);
    endtask

    task automatic udr_pulse(string tag);
        vs_udr = 1; tick(tag); tick(tag);
        vs_udr = 0; tick(tag);
    endtask

    typedef struct {
        logic            uir, udr;
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] sr;
        logic            rdy, clr;
        logic            valid;
        logic [IR_W-1:0] eir;
        logic [DR_W-1:0] ejdo;
        logic [3:0]      eta, etna;
        logic            eovr;
        logic [OVR_W-1:0] ecnt;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t v(logic u, logic d, logic [IR_W-1:0] ir, logic [DR_W-1:0] s,
                               logic rdy, logic clr, logic val, logic [IR_W-1:0] eir,
                               logic [DR_W-1:0] ejdo, logic [3:0] eta, logic [3:0] etna,
                               logic eovr, logic [OVR_W-1:0] ecnt);
        vec_t r;
        r.uir = u; r.udr = d; r.ir = ir; r.sr = s; r.rdy = rdy; r.clr = clr;
        r.valid = val; r.eir = eir; r.ejdo = ejdo; r.eta = eta; r.etna = etna;
        r.eovr = eovr; r.ecnt = ecnt;
        return r;
    endfunction

    int valid_cycles;
    logic [IR_W-1:0] seen_ir;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic decode
        tbl[0]  = v(1,0,1,VA,1,0, 0,0,VZ,0,0,0,0);
        tbl[1]  = v(1,0,1,VA,1,0, 0,0,VZ,0,0,0,0);
        tbl[2]  = v(0,0,1,VA,1,0, 0,0,VZ,0,0,0,0);
        tbl[3]  = v(0,1,1,VA,1,0, 0,0,VZ,0,0,0,0);
        tbl[4]  = v(0,1,1,VA,1,0, 0,0,VZ,0,0,0,0);
        tbl[5]  = v(0,0,1,VA,1,0, 1,1,VA,4'b0010,0,0,0);
        tbl[6]  = v(0,0,1,VA,1,0, 0,1,VA,0,0,0,0);
        // back-pressure: A held, B dropped
        tbl[7]  = v(0,1,1,VA,0,0, 0,1,VA,0,0,0,0);
        tbl[8]  = v(0,1,1,VA,0,0, 0,1,VA,0,0,0,0);
        tbl[9]  = v(0,0,1,VA,0,0, 1,1,VA,4'b0010,0,0,0);
        tbl[10] = v(0,1,1,VB,0,0, 1,1,VA,4'b0010,0,0,0);
        tbl[11] = v(0,1,1,VB,0,0, 1,1,VA,4'b0010,0,0,0);
        tbl[12] = v(0,0,1,VB,0,0, 1,1,VA,4'b0010,0,1,1);
        tbl[13] = v(0,0,1,VB,1,0, 0,1,VA,0,0,1,1);
        tbl[14] = v(0,0,1,VB,1,0, 0,1,VA,0,0,1,1);
        // clear, then accept and reload on the same edge
        tbl[15] = v(0,1,1,VC,0,1, 0,1,VA,0,0,0,0);
        tbl[16] = v(0,1,1,VC,0,0, 0,1,VA,0,0,0,0);
        tbl[17] = v(0,0,1,VC,0,0, 1,1,VC,0,4'b0010,0,0);
        tbl[18] = v(0,1,1,VD,0,0, 1,1,VC,0,4'b0010,0,0);
        tbl[19] = v(0,1,1,VD,0,0, 1,1,VC,0,4'b0010,0,0);
        tbl[20] = v(0,0,1,VD,1,0, 1,1,VD,4'b0010,0,0,0);
        tbl[21] = v(0,0,1,VD,1,0, 0,1,VD,0,0,0,0);

        reset_n = 0; vs_uir = 0; vs_udr = 0; ir_in = '0; sr = '0;
        clr_overrun = 0; bus.cmd_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 64'(bus.cmd_valid), 64'd0);
        chk("rst.ta", 64'(bus.take_action), 64'd0);
        reset_n = 1;
        model_reset();

        // directed vector table
        for (int i = 0; i < 22; i++) begin
            vs_uir = tbl[i].uir; vs_udr = tbl[i].udr; ir_in = tbl[i].ir; sr = tbl[i].sr;
            bus.cmd_ready = tbl[i].rdy; clr_overrun = tbl[i].clr;
            tick($sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.valid", i), 64'(bus.cmd_valid), 64'(tbl[i].valid));
            chk($sformatf("tbl%0d.ir", i), 64'(bus.cmd_ir), 64'(tbl[i].eir));
            chk($sformatf("tbl%0d.jdo", i), 64'(bus.jdo), 64'(tbl[i].ejdo));
            chk($sformatf("tbl%0d.ta", i), 64'(bus.take_action), 64'(tbl[i].eta));
            chk($sformatf("tbl%0d.tna", i), 64'(bus.take_no_action), 64'(tbl[i].etna));
            chk($sformatf("tbl%0d.ovr", i), 64'(overrun), 64'(tbl[i].eovr));
            chk($sformatf("tbl%0d.cnt", i), 64'(overrun_count), 64'(tbl[i].ecnt));
        end
        clr_overrun = 0;

        // saturation: one load then five drops
        bus.cmd_ready = 0; sr = VB;
        udr_pulse("sat");
        for (int i = 0; i < 5; i++) udr_pulse("sat");
        chk("sat.cnt", 64'(overrun_count), 64'd3);
        chk("sat.ovr", 64'(overrun), 64'd1);
        chk("sat.jdo", 64'(bus.jdo), 64'(VB));
        clr_overrun = 1; tick("clr"); clr_overrun = 0;
        chk("clr.cnt", 64'(overrun_count), 64'd0);
        chk("clr.ovr", 64'(overrun), 64'd0);
        vs_udr = 1; tick("clrdrop"); tick("clrdrop");
        vs_udr = 0; clr_overrun = 1; tick("clrdrop"); clr_overrun = 0;
        chk("clrdrop.cnt", 64'(overrun_count), 64'd1);
        chk("clrdrop.ovr", 64'(overrun), 64'd1);
        bus.cmd_ready = 1; tick("drain");

        // coincident IR/DR rise and a 100-cycle DR level
        ir_in = 2'b11; vs_uir = 1; vs_udr = 1; sr = VA;
        valid_cycles = 0; seen_ir = '0;
        for (int i = 0; i < 100; i++) begin
            tick("level");
            if (bus.cmd_valid) begin
                valid_cycles++;
                seen_ir = bus.cmd_ir;
            end
        end
        vs_uir = 0; vs_udr = 0;
        repeat (4) tick("level");
        chk("level.count", 64'(valid_cycles), 64'd1);
        chk("coinc.ir", 64'(seen_ir), 64'd3);

        // asynchronous reset mid-operation with a pending command and overrun
        bus.cmd_ready = 0; sr = VD;
        udr_pulse("pre"); udr_pulse("pre");
        chk("pre.valid", 64'(bus.cmd_valid), 64'd1);
        vs_udr = 1;
        #2 reset_n = 0;
        #1;
        chk("arst.valid", 64'(bus.cmd_valid), 64'd0);
        chk("arst.jdo", 64'(bus.jdo), 64'd0);
        chk("arst.ta", 64'(bus.take_action), 64'd0);
        chk("arst.ovr", 64'(overrun), 64'd0);
        chk("arst.cnt", 64'(overrun_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rsthold.valid", 64'(bus.cmd_valid), 64'd0);
        reset_n = 1;
        model_reset();
        tick("rel"); tick("rel");
        chk("rel2.valid", 64'(bus.cmd_valid), 64'd0);
        tick("rel");
        chk("rel3.valid", 64'(bus.cmd_valid), 64'd1);
        chk("rel3.jdo", 64'(bus.jdo), 64'(VD));
        bus.cmd_ready = 1;
        repeat (10) tick("relhold");
        chk("relhold.valid", 64'(bus.cmd_valid), 64'd0);
        vs_udr = 0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
            if ($urandom_range(0, 4) == 0) vs_udr = ~vs_udr;
            ir_in = IR_W'($urandom);
            sr = {6'($urandom), 32'($urandom)};
            bus.cmd_ready = ($urandom_range(0, 2) != 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
